// File: rtl/sector_pingpong_buffer.sv
// Two-bank (ping-pong) SD sector buffer: the SPI side fills one bank while the
// consumer drains the other, with internally generated write/read indices.
module sector_pingpong_buffer #(
  parameter int DATA_W       = 8,
  parameter int SECTOR_WORDS = 512,
  parameter int ADDR_W       = $clog2(SECTOR_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              wr_flush,
  output logic              rd_avail,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        full_cnt,
  output logic              overrun
);

  localparam int                MEM_DEPTH = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SECTOR_WORDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [1:0]        r_bank_full;
  logic [1:0]        r_full_cnt;
  logic              r_overrun;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic [ADDR_W-1:0] w_wr_idx_nxt;
  logic [ADDR_W-1:0] w_rd_idx_nxt;
  logic              w_wr_bank_nxt;
  logic              w_rd_bank_nxt;
  logic [1:0]        w_bank_full_nxt;
  logic [1:0]        w_full_cnt_nxt;

  logic              w_wr_ready;
  logic              w_rd_avail;
  logic              w_wr_accept;
  logic              w_rd_accept;
  logic              w_wr_done;
  logic              w_rd_done;
  logic              w_overrun_set;
  logic [ADDR_W:0]   w_wr_addr;
  logic [ADDR_W:0]   w_rd_addr;

  // Handshake decode from registered bank state; a flush suppresses the write
  always_comb begin
    w_wr_ready    = ~r_bank_full[r_wr_bank];
    w_rd_avail    = r_bank_full[r_rd_bank];
    w_wr_accept   = wr_valid & w_wr_ready & ~wr_flush;
    w_rd_accept   = rd_en & w_rd_avail;
    w_wr_done     = w_wr_accept & (r_wr_idx == LAST_IDX);
    w_rd_done     = w_rd_accept & (r_rd_idx == LAST_IDX);
    w_overrun_set = wr_valid & ~w_wr_ready;
    w_wr_addr     = {r_wr_bank, r_wr_idx};
    w_rd_addr     = {r_rd_bank, r_rd_idx};
  end

  // Next-state logic for indices, bank pointers, bank states and sector count
  always_comb begin
    w_wr_idx_nxt    = r_wr_idx;
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_idx_nxt    = r_rd_idx;
    w_rd_bank_nxt   = r_rd_bank;
    w_bank_full_nxt = r_bank_full;
    w_full_cnt_nxt  = r_full_cnt;

    if (wr_flush) begin
      w_wr_idx_nxt = '0;
    end else if (w_wr_done) begin
      w_wr_idx_nxt               = '0;
      w_wr_bank_nxt              = ~r_wr_bank;
      w_bank_full_nxt[r_wr_bank] = 1'b1;
    end else if (w_wr_accept) begin
      w_wr_idx_nxt = r_wr_idx + IDX_ONE;
    end else begin
      w_wr_idx_nxt = r_wr_idx;
    end

    // Completion and drain always target different banks, so both may apply
    if (w_rd_done) begin
      w_rd_idx_nxt               = '0;
      w_rd_bank_nxt              = ~r_rd_bank;
      w_bank_full_nxt[r_rd_bank] = 1'b0;
    end else if (w_rd_accept) begin
      w_rd_idx_nxt = r_rd_idx + IDX_ONE;
    end else begin
      w_rd_idx_nxt = r_rd_idx;
    end

    case ({w_wr_done, w_rd_done})
      2'b10:   w_full_cnt_nxt = r_full_cnt + 2'd1;
      2'b01:   w_full_cnt_nxt = r_full_cnt - 2'd1;
      default: w_full_cnt_nxt = r_full_cnt;
    endcase
  end

  // Control state and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_full_cnt  <= 2'd0;
      r_overrun   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_wr_idx    <= w_wr_idx_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_bank_full <= w_bank_full_nxt;
      r_full_cnt  <= w_full_cnt_nxt;
      r_overrun   <= r_overrun | w_overrun_set;
      r_rd_valid  <= w_rd_accept;
      r_rd_last   <= w_rd_done;
      if (w_rd_accept) begin
        r_rd_data <= r_mem[w_rd_addr];
      end
    end
  end

  // Sector storage write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_avail = w_rd_avail;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_last  = r_rd_last;
  assign full_cnt = r_full_cnt;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_sector_pingpong_buffer.sv
// Directed bench for sector_pingpong_buffer: a table of sector-level operations
// with hand-computed status, plus reset-mid-read and ping-pong overlap sequences.
module tb_sector_pingpong_buffer;

  localparam int SW = 512;

  localparam int OP_WR  = 0;
  localparam int OP_RD  = 1;
  localparam int OP_FL  = 2;
  localparam int OP_RDE = 3;

  // exp_st = {wr_ready, rd_avail, full_cnt[1:0], overrun}
  typedef struct {
    int       op;
    int       pat;
    int       n;
    logic [4:0] exp_st;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       wr_flush;
  logic       rd_avail;
  logic       rd_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic [1:0] full_cnt;
  logic       overrun;

  int n_vec;
  int n_err;
  vec_t vecs[12];

  sector_pingpong_buffer #(.DATA_W(8), .SECTOR_WORDS(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_flush(wr_flush),
    .rd_avail(rd_avail), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .full_cnt(full_cnt), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int p, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (p)
      0:       return b;
      1:       return b ^ 8'hA5;
      2:       return 8'((i * 7) + 3);
      default: return ~b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic wv, input logic [7:0] wd, input logic wf, input logic re);
    wr_valid = wv;
    wr_data  = wd;
    wr_flush = wf;
    rd_en    = re;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int p, input int n);
    for (int i = 0; i < n; i++) step(1'b1, pat(p, i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_read(input string name, input int p);
    int bad;
    int first;
    logic [7:0] got_d;
    logic got_v;
    logic got_l;
    bad = 0;
    first = -1;
    got_d = 8'h00;
    got_v = 1'b0;
    got_l = 1'b0;
    for (int i = 0; i < SW; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      if (rd_valid !== 1'b1 || rd_data !== pat(p, i) || rd_last !== (i == SW - 1)) begin
        if (bad == 0) begin
          first = i;
          got_d = rd_data;
          got_v = rd_valid;
          got_l = rd_last;
        end
        bad++;
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d bad words, first idx %0d got data=%h valid=%0b last=%0b expected data=%h last=%0b",
               name, bad, first, got_d, got_v, got_l, pat(p, first), (first == SW - 1));
    end
  endtask

  initial begin
    int seen_valid;
    int max_cnt;
    int bad;
    int p;

    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    wr_flush = 1'b0;
    rd_en    = 1'b0;

    vecs[0]  = '{OP_WR,  0, SW,  5'b1_1_01_0};
    vecs[1]  = '{OP_RD,  0, SW,  5'b1_0_00_0};
    vecs[2]  = '{OP_RDE, 0, 3,   5'b1_0_00_0};
    vecs[3]  = '{OP_WR,  1, SW,  5'b1_1_01_0};
    vecs[4]  = '{OP_WR,  2, SW,  5'b0_1_10_0};
    vecs[5]  = '{OP_WR,  3, 5,   5'b0_1_10_1};
    vecs[6]  = '{OP_RD,  1, SW,  5'b1_1_01_1};
    vecs[7]  = '{OP_RD,  2, SW,  5'b1_0_00_1};
    vecs[8]  = '{OP_WR,  3, 100, 5'b1_0_00_1};
    vecs[9]  = '{OP_FL,  0, 1,   5'b1_0_00_1};
    vecs[10] = '{OP_WR,  1, SW,  5'b1_1_01_1};
    vecs[11] = '{OP_RD,  1, SW,  5'b1_0_00_1};

    #12;
    chk("reset_status", {27'd0, wr_ready, rd_avail, full_cnt, overrun}, 32'b1_0_00_0);
    chk("reset_rd_out", {22'd0, rd_valid, rd_last, rd_data}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      case (vecs[v].op)
        OP_WR: do_write(vecs[v].pat, vecs[v].n);
        OP_RD: do_read($sformatf("vec%0d_rd_data", v), vecs[v].pat);
        OP_FL: step(1'b1, 8'hEE, 1'b1, 1'b0);
        default: begin
          seen_valid = 0;
          for (int i = 0; i < vecs[v].n; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (rd_valid === 1'b1) seen_valid++;
          end
          chk($sformatf("vec%0d_pop_empty", v), seen_valid, 0);
        end
      endcase
      chk($sformatf("vec%0d_status", v), {27'd0, wr_ready, rd_avail, full_cnt, overrun}, {27'd0, vecs[v].exp_st});
    end

    // Asynchronous reset in the middle of a drain
    do_write(0, SW);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pre_reset_rd", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, pat(0, 9)});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_status", {27'd0, wr_ready, rd_avail, full_cnt, overrun}, 32'b1_0_00_0);
    chk("async_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_write(3, SW);
    chk("post_reset_status", {27'd0, wr_ready, rd_avail, full_cnt, overrun}, 32'b1_1_01_0);
    do_read("post_reset_rd_data", 3);

    // Ping-pong overlap: sectors A,B,C written back to back, draining from A's completion
    bad = 0;
    max_cnt = 0;
    for (int c = 0; c < 4 * SW; c++) begin
      step((c < 3 * SW), (c < 3 * SW) ? pat(c / SW, c % SW) : 8'h00, 1'b0, (c >= SW));
      if (int'(full_cnt) > max_cnt) max_cnt = int'(full_cnt);
      if (c >= SW) begin
        p = c - SW;
        if (rd_valid !== 1'b1 || rd_data !== pat(p / SW, p % SW) || rd_last !== ((p % SW) == SW - 1)) begin
          if (bad == 0)
            $display("FAIL overlap_word: idx %0d got data=%h valid=%0b last=%0b expected %h",
                     p, rd_data, rd_valid, rd_last, pat(p / SW, p % SW));
          bad++;
        end
      end
      if (c == 2 * SW - 1)
        chk("simul_complete_free", {29'd0, rd_avail, full_cnt}, {29'd0, 1'b1, 2'd1});
    end
    chk("overlap_bad_words", bad, 0);
    chk("overlap_max_full_cnt", max_cnt, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("overlap_end_status", {27'd0, wr_ready, rd_avail, full_cnt, overrun}, 32'b1_0_00_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sector_pingpong_buffer.md
# sector_pingpong_buffer

Parametrised two-bank (ping-pong) sector buffer between the SPI byte receiver and downstream consumers of SD-card sector data. The SPI side streams one full sector into one bank while the consumer drains the previously completed sector from the other bank. Read and write addresses are generated internally. Handshakes replace raw address and write-enable control. Overrun is flagged and never corrupts a completed sector.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- SECTOR_WORDS, 512, words per sector and per bank; must be ≥2.
- ADDR_W, $clog2(SECTOR_WORDS), per-bank index width; derived, do not override.

Ports:
- clk  in  1  single clock for all logic; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  a word is offered on wr_data.
- wr_data  in  DATA_W  incoming SPI word.
- wr_ready  out  1  a bank is available for writing.
- wr_flush  in  1  discard the partially written sector; write index returns to 0.
- rd_avail  out  1  a completed sector is readable.
- rd_en  in  1  pop one word; ignored when rd_avail=0.
- rd_valid  out  1  rd_data holds a popped word this cycle.
- rd_data  out  DATA_W  popped word.
- rd_last  out  1  qualifies rd_valid; the word is the last of its sector.
- full_cnt  out  2  number of completed, unread sectors (0..2).
- overrun  out  1  sticky: wr_valid was asserted while wr_ready=0; cleared only by reset.

## Operation
- Storage: 2×SECTOR_WORDS words, inferred as synchronous block RAM with a 1-cycle registered read.
- Bank state: each bank is FREE or FULL. wr_bank selects the bank being filled. rd_bank selects the bank being drained.
- wr_ready = (bank[wr_bank]==FREE).
- A write accepts when wr_valid && wr_ready. It stores mem[wr_bank][wr_idx] and increments wr_idx.
- When a write is accepted with wr_idx==SECTOR_WORDS-1:
  - bank[wr_bank] becomes FULL.
  - wr_idx wraps to 0.
  - wr_bank toggles.
- rd_avail = (bank[rd_bank]==FULL).
- A pop accepts when rd_en && rd_avail. It reads mem[rd_bank][rd_idx] and increments rd_idx.
- When a pop is accepted with rd_idx==SECTOR_WORDS-1:
  - bank[rd_bank] becomes FREE.
  - rd_idx wraps to 0.
  - rd_bank toggles.
  - The word returned next cycle carries rd_last=1.
- full_cnt = count of FULL banks. Each sector completion increments it and each sector drain decrements it. If both happen in the same cycle, full_cnt is unchanged.
- wr_flush:
  - Sets wr_idx to 0. Words already written to the current bank are abandoned.
  - Does not change bank states, the read side, or overrun.
  - If wr_flush and an accepted write occur in the same cycle, wr_flush wins and the word is dropped.
- Overrun: a write attempted while wr_ready=0 is dropped and sets overrun. The data in FULL banks is preserved.
- Sectors are read in the order they were completed; banks alternate strictly.

## Timing
- Reset (asynchronous, while rst_n=0):
  - rd_valid=0, rd_data=0, rd_last=0, full_cnt=0, overrun=0.
  - wr_ready=1, rd_avail=0.
  - wr_idx=rd_idx=0, wr_bank=rd_bank=0, both banks FREE.
  - RAM contents are not cleared.
- Read latency: a pop accepted in cycle N gives rd_valid=1 with rd_data and rd_last in cycle N+1. With rd_en held high, one word is returned per cycle.
- Status update: a bank state change in cycle N (FULL on last write, FREE on last pop) is visible on wr_ready, rd_avail and full_cnt in cycle N+1.
  - A sector completed in cycle N can be popped from N+1.
  - A bank freed in cycle N can accept writes from N+1.
- Throughput: the write and read sides are independent and can each move one word per cycle in the same cycle.
- Reset mid-sector: all progress is lost. The next accepted write goes to bank 0, index 0.

## Test plan
- Fill-and-drain, SECTOR_WORDS=512: write bytes 0x00..0xFF twice (512 words). Expect rd_avail=1 and full_cnt=1 the cycle after the 512th write. Pop 512 words and expect the same sequence, with rd_last only on the 512th word and full_cnt back to 0.
- Ping-pong overlap: continuous writes of 3 sectors (patterns A, B, C) while draining at 1 word/cycle, starting after sector A completes. Expect all 1536 words in order A, B, C, full_cnt never exceeding 2, and overrun=0.
- Overrun: write 2 full sectors with no pops, then 5 more words. Expect wr_ready=0 after the 1024th write, overrun=1, and both sectors read back intact.
- Flush: write 100 words, pulse wr_flush together with a write of 0xEE, then write a 512-word pattern. Expect the first sector read to equal the new pattern exactly, with no 0xEE.
- Simultaneous complete/free: with bank 0 FULL, the last pop of bank 0 and the last write of bank 1 in the same cycle. Expect full_cnt to stay at 1, and bank 1 to be readable the next cycle.
- Async reset mid-read: assert rst_n=0 between clock edges during a drain. Expect rd_valid, rd_avail and full_cnt to go to 0 immediately, wr_ready=1, and the next sector to land in bank 0.
